// File: rtl/fl_channel_serializer.sv
// Collects 32-channel output bundles from FIRST_LAYER into a small FIFO and drains them
// as a serialized word stream tagged with channel, column and row indices.
module fl_channel_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CH         = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ROW_LEN    = 147,
    parameter int unsigned ROWS       = 147
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic [CH*DATA_WIDTH-1:0]   pxl_in,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      pxl_out,
    output logic [$clog2(CH)-1:0]      ch_idx,
    output logic [$clog2(ROW_LEN)-1:0] col_idx,
    output logic [$clog2(ROWS)-1:0]    row_idx,
    output logic                       last_out,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = $clog2(CH);
    localparam int unsigned COL_W = $clog2(ROW_LEN);
    localparam int unsigned ROW_W = $clog2(ROWS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    logic [CH*DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    logic                     push;
    logic                     drop;
    logic                     xfer;
    logic                     ch_last;
    logic                     pop;
    logic [CH*DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]    head_words [CH];
    logic [DATA_WIDTH-1:0]    head_word;

    // Status comes from the registered count only, so a pop never frees a slot same-cycle.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);

    assign push    = valid_in && in_ready;
    assign drop    = valid_in && !in_ready;
    assign xfer    = out_valid && out_ready;
    assign ch_last = (ch_q == CH_LAST);
    assign pop     = xfer && ch_last;

    assign head = mem[rd_ptr_q];

    for (genvar c = 0; c < CH; c++) begin : g_split
        assign head_words[c] = head[c*DATA_WIDTH +: DATA_WIDTH];
    end

    assign head_word = head_words[ch_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pxl_in;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ch_d       = ch_q;
        col_d      = col_q;
        row_d      = row_q;
        overflow_d = overflow_q;
        hold_d     = hold_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end

        if (xfer) begin
            // Remember the accepted word so pxl_out holds it once the FIFO runs dry.
            hold_d = head_word;
            if (ch_last) begin
                ch_d = '0;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end else begin
                ch_d = ch_q + CH_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ch_q       <= ch_d;
            col_q      <= col_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
        end
    end

    assign pxl_out  = out_valid ? head_word : hold_q;
    assign ch_idx   = ch_q;
    assign col_idx  = col_q;
    assign row_idx  = row_q;
    assign overflow = overflow_q;
    assign last_out = out_valid && ch_last && (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: tb/tb_fl_channel_serializer.sv
// Randomized bench for fl_channel_serializer using a small 3x2 frame so wrap and
// last-word behaviour is reachable; expectations come from a bundle-queue model.
module tb_fl_channel_serializer;

    localparam int DW    = 32;
    localparam int CH    = 32;
    localparam int DEPTH = 4;
    localparam int RL    = 3;
    localparam int RW    = 2;
    localparam int CHW   = $clog2(CH);
    localparam int CW    = $clog2(RL);
    localparam int RWW   = $clog2(RW);

    logic                clk;
    logic                reset;
    logic                valid_in;
    logic [CH*DW-1:0]    pxl_in;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       pxl_out;
    logic [CHW-1:0]      ch_idx;
    logic [CW-1:0]       col_idx;
    logic [RWW-1:0]      row_idx;
    logic                last_out;
    logic                overflow;

    int checks;
    int errors;

    // Reference model: queue of buffered bundles plus a running word position.
    logic [CH*DW-1:0] mq [$];
    int               m_ch;
    int               m_bnum;
    bit               m_ovf;

    fl_channel_serializer #(
        .DATA_WIDTH(DW),
        .CH        (CH),
        .DEPTH     (DEPTH),
        .ROW_LEN   (RL),
        .ROWS      (RW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .pxl_in   (pxl_in),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pxl_out  (pxl_out),
        .ch_idx   (ch_idx),
        .col_idx  (col_idx),
        .row_idx  (row_idx),
        .last_out (last_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH*DW-1:0] rand_bundle();
        logic [CH*DW-1:0] b;
        for (int i = 0; i < CH; i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    function automatic logic [CH*DW-1:0] tag_bundle(input int k);
        logic [CH*DW-1:0] b;
        for (int i = 0; i < CH; i++) b[i*DW +: DW] = DW'((k << 8) | i);
        return b;
    endfunction

    function automatic logic [DW-1:0] m_word();
        logic [CH*DW-1:0] b;
        b = mq[0];
        return b[m_ch*DW +: DW];
    endfunction

    function automatic int m_col();
        return m_bnum % RL;
    endfunction

    function automatic int m_row();
        return (m_bnum / RL) % RW;
    endfunction

    function automatic bit m_last();
        return (mq.size() != 0) && (m_ch == CH - 1) && ((m_bnum % (RL * RW)) == RL * RW - 1);
    endfunction

    // Drive one cycle at the falling edge, advance the model, return at the next falling edge.
    task automatic step(input bit v, input logic [CH*DW-1:0] d, input bit rdy);
        bit xfer;
        bit acc;
        valid_in  = v;
        pxl_in    = d;
        out_ready = rdy;
        xfer = (mq.size() != 0) && rdy;
        acc  = v && (mq.size() < DEPTH);
        if (v && !acc) m_ovf = 1'b1;
        if (xfer) begin
            if (m_ch == CH - 1) begin
                mq.delete(0);
                m_ch = 0;
                m_bnum++;
            end else begin
                m_ch++;
            end
        end
        if (acc) mq.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        mq.delete();
        m_ch   = 0;
        m_bnum = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        valid_in  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        pxl_in    = '0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 || last_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b r=%b ovf=%b last=%b want 0 1 0 0",
                     out_valid, in_ready, overflow, last_out);
        end
        checks++;
        if (ch_idx !== '0 || col_idx !== '0 || row_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx: got ch=%0d col=%0d row=%0d want 0 0 0",
                     ch_idx, col_idx, row_idx);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [CH*DW-1:0] b;
        for (int c = 0; c < CH; c++) b[c*DW +: DW] = DW'(32'h100 + c);
        step(1'b1, b, 1'b1);
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || pxl_out !== DW'(32'h100 + i) || ch_idx !== CHW'(i)) begin
                errors++;
                $display("FAIL single_word%0d: got v=%b d=%h ch=%0d want 1 %h %0d",
                         i, out_valid, pxl_out, ch_idx, 32'h100 + i, i);
            end
            step(1'b0, '0, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_empty: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit pat [4];
        int n;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        step(1'b1, rand_bundle(), 1'b0);
        step(1'b1, rand_bundle(), 1'b0);
        n = 0;
        while (mq.size() != 0 && n < 400) begin
            checks++;
            if (out_valid !== 1'b1 || pxl_out !== m_word() || ch_idx !== CHW'(m_ch)) begin
                errors++;
                $display("FAIL bp_word: got v=%b d=%h ch=%0d want 1 %h %0d",
                         out_valid, pxl_out, ch_idx, m_word(), m_ch);
            end
            step(1'b0, '0, pat[n % 4]);
            n++;
        end
        checks++;
        if (mq.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b left=%0d want 0 0", out_valid, mq.size());
        end
    endtask

    task automatic test_overflow();
        int n;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: got %b want 0", overflow);
                end
            end
            step(1'b1, tag_bundle(k), 1'b0);
            checks++;
            if (in_ready !== (k < 4)) begin
                errors++;
                $display("FAIL ovf_ready%0d: got %b want %b", k, in_ready, k < 4);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        n = 0;
        while (n < 4 * CH) begin
            checks++;
            if (out_valid !== 1'b1 || pxl_out !== DW'((((n / CH) + 1) << 8) | (n % CH))) begin
                errors++;
                $display("FAIL ovf_drain%0d: got v=%b d=%h want 1 %h",
                         n, out_valid, pxl_out, (((n / CH) + 1) << 8) | (n % CH));
            end
            step(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: got v=%b ovf=%b want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [CH*DW-1:0] b;
        step(1'b1, rand_bundle(), 1'b0);
        step(1'b1, rand_bundle(), 1'b0);
        repeat (5) step(1'b0, '0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 || ch_idx !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b r=%b ovf=%b ch=%0d want 0 1 0 0",
                     out_valid, in_ready, overflow, ch_idx);
        end
        valid_in  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        b = rand_bundle();
        step(1'b1, b, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || pxl_out !== b[DW-1:0] || ch_idx !== '0 || col_idx !== '0 ||
            row_idx !== '0) begin
            errors++;
            $display("FAIL rst_first: got v=%b d=%h ch=%0d col=%0d row=%0d want 1 %h 0 0 0",
                     out_valid, pxl_out, ch_idx, col_idx, row_idx, b[DW-1:0]);
        end
    endtask

    task automatic test_wrap();
        int exp_col [7];
        int exp_row [7];
        int pushes;
        int n;
        int lasts;
        bit v;
        exp_col = '{0, 1, 2, 0, 1, 2, 0};
        exp_row = '{0, 0, 0, 1, 1, 1, 0};
        do_reset();
        pushes = 7;
        lasts  = 0;
        n      = 0;
        while ((pushes > 0 || mq.size() != 0) && n < 800) begin
            if (mq.size() != 0 && m_bnum < 7) begin
                checks++;
                if (out_valid !== 1'b1 || col_idx !== CW'(exp_col[m_bnum]) ||
                    row_idx !== RWW'(exp_row[m_bnum]) || ch_idx !== CHW'(m_ch) ||
                    last_out !== (m_bnum == 5 && m_ch == CH - 1)) begin
                    errors++;
                    $display("FAIL wrap_b%0d_c%0d: got v=%b col=%0d row=%0d ch=%0d last=%b want 1 %0d %0d %0d %b",
                             m_bnum, m_ch, out_valid, col_idx, row_idx, ch_idx, last_out,
                             exp_col[m_bnum], exp_row[m_bnum], m_ch, m_bnum == 5 && m_ch == CH - 1);
                end
                if (last_out === 1'b1) lasts++;
            end
            v = (pushes > 0) && (mq.size() < DEPTH);
            step(v, rand_bundle(), 1'b1);
            if (v) pushes--;
            n++;
        end
        checks++;
        if (lasts != 1 || mq.size() != 0) begin
            errors++;
            $display("FAIL wrap_last_count: got %0d left=%0d want 1 0", lasts, mq.size());
        end
    endtask

    task automatic test_simul();
        int n;
        do_reset();
        step(1'b1, tag_bundle(1), 1'b0);
        step(1'b1, tag_bundle(2), 1'b0);
        repeat (CH - 1) step(1'b0, '0, 1'b1);
        checks++;
        if (ch_idx !== CH_LAST_T() || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL simul_pre: got ch=%0d v=%b want %0d 1", ch_idx, out_valid, CH - 1);
        end
        // Push lands on the same edge as the final-channel pop: count stays at 2.
        step(1'b1, tag_bundle(3), 1'b1);
        step(1'b1, tag_bundle(4), 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_cnt3: got in_ready=%b want 1", in_ready);
        end
        step(1'b1, tag_bundle(5), 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_cnt4: got in_ready=%b want 0", in_ready);
        end
        n = 0;
        while (n < 4 * CH) begin
            checks++;
            if (out_valid !== 1'b1 || pxl_out !== DW'((((n / CH) + 2) << 8) | (n % CH))) begin
                errors++;
                $display("FAIL simul_order%0d: got v=%b d=%h want 1 %h",
                         n, out_valid, pxl_out, (((n / CH) + 2) << 8) | (n % CH));
            end
            step(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got v=%b want 0", out_valid);
        end
    endtask

    function automatic logic [CHW-1:0] CH_LAST_T();
        return CHW'(CH - 1);
    endfunction

    task automatic test_random();
        int n;
        for (int i = 0; i < 1500; i++) begin
            checks++;
            if (in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() != 0) ||
                overflow !== m_ovf || last_out !== m_last()) begin
                errors++;
                $display("FAIL rand_flags%0d: got r=%b v=%b ovf=%b last=%b want %b %b %b %b",
                         i, in_ready, out_valid, overflow, last_out, mq.size() < DEPTH,
                         mq.size() != 0, m_ovf, m_last());
            end
            if (mq.size() != 0) begin
                checks++;
                if (pxl_out !== m_word() || ch_idx !== CHW'(m_ch) || col_idx !== CW'(m_col()) ||
                    row_idx !== RWW'(m_row())) begin
                    errors++;
                    $display("FAIL rand_word%0d: got d=%h ch=%0d col=%0d row=%0d want %h %0d %0d %0d",
                             i, pxl_out, ch_idx, col_idx, row_idx, m_word(), m_ch, m_col(), m_row());
                end
            end
            step(($urandom % 8) == 0, rand_bundle(), ($urandom % 4) != 0);
        end
        n = 0;
        while (mq.size() != 0 && n < 400) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (out_valid !== 1'b0 || mq.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got v=%b left=%0d want 0 0", out_valid, mq.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_simul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fl_channel_serializer.md
# fl_channel_serializer

Output-side collector for FIRST_LAYER. Captures the 32 parallel channel pixels the layer presents on each output strobe into a small bundle FIFO and drains them as one serialized word stream with a valid/ready handshake. Each word carries its channel, column and row index, so a downstream memory writer or the next layer's loader can consume the 147x147x32 feature map one word per cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one pixel word
- CH, 32, channels per bundle
- DEPTH, 4, bundle FIFO depth (power of 2)
- ROW_LEN, 147, output columns per row
- ROWS, 147, output rows per frame

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  bundle strobe, driven from FIRST_LAYER valid_out_1
- pxl_in  in  CH*DATA_WIDTH  channel c+1 (pxl_out_{c+1}) at bits [c*DATA_WIDTH +: DATA_WIDTH]
- in_ready  out  1  FIFO not full
- out_valid  out  1  pxl_out holds a valid word
- out_ready  in  1  downstream accepts word
- pxl_out  out  DATA_WIDTH  serialized pixel
- ch_idx  out  $clog2(CH)  channel of pxl_out, 0-based
- col_idx  out  $clog2(ROW_LEN)  column of current bundle
- row_idx  out  $clog2(ROWS)  row of current bundle
- last_out  out  1  final word of the frame
- overflow  out  1  sticky: a bundle was dropped

## Operation
- Push: valid_in && in_ready writes pxl_in into FIFO at wr_ptr; count +1.
- Drop: valid_in && !in_ready discards the bundle and sets overflow. overflow clears only on reset.
- in_ready = (count != DEPTH), from registered count only. A pop in the same cycle does not open a slot for a push while full.
- out_valid = (count != 0). pxl_out = head bundle word at ch_cnt.
- Handshake: a word transfers when out_valid && out_ready. ch_cnt increments per transfer. At ch_cnt == CH-1 the transfer pops the head, sets ch_cnt to 0 and advances position.
- Position after pop: col increments, wrapping at ROW_LEN-1 to 0 and incrementing row. Row wraps at ROWS-1 to 0.
- last_out = out_valid && ch_cnt==CH-1 && col==ROW_LEN-1 && row==ROWS-1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- When out_valid is low, pxl_out, ch_idx, col_idx and row_idx hold their last values. Downstream ignores them.

## Timing
- Reset (reset==0, asynchronous) clears count, pointers, ch_cnt, col, row and overflow. Outputs after reset: out_valid=0, in_ready=1, ch_idx=0, col_idx=0, row_idx=0, last_out=0, overflow=0. pxl_out is the don't-care FIFO contents.
- Reset asserted mid-frame aborts immediately. Buffered bundles are lost and indices restart at 0,0,0.
- Latency: a bundle pushed at edge k gives out_valid=1 from edge k onward, with channel 0 on pxl_out in cycle k+1.
- Throughput: 1 word/cycle; one bundle drains in CH cycles with out_ready held high.
- out_valid never drops while count != 0. pxl_out and the indices stay stable while out_valid && !out_ready.

## Test plan
- Reset: assert reset=0 mid-stream. Required: out_valid=0, in_ready=1 and overflow=0 asynchronously. After release, the first word has ch_idx=0, col_idx=0, row_idx=0.
- Single bundle: channel c = 32'h100+c, out_ready=1. Required: 32 consecutive words 0x100..0x11F with ch_idx 0..31, then out_valid=0 and count=0.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly. Required: no word duplicated or skipped, and pxl_out stays stable during stalls.
- Full/overflow with DEPTH=4: out_ready=0 and five bundles pushed. Required: in_ready=0 after the 4th; the 5th is dropped and overflow=1. Draining then yields bundles 1..4 in order.
- Wrap with ROW_LEN=3, ROWS=2: six bundles. Required: col 0,1,2,0,1,2 and row 0,0,0,1,1,1. last_out=1 only on bundle 6, ch_idx=31. A 7th bundle reports col=0, row=0.
- Simultaneous push/pop at count=2: push coincides with the final-channel pop. Required: count stays 2 and order is preserved.
